// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline register: DEPTH chained slices, each with a main and a skid entry.
// Ready toward upstream is registered (!skid valid), so out_ready never reaches in_ready combinationally.
module pipe_elastic_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4,
    parameter int DEPTH      = 1,
    parameter int OCC_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [OCC_WIDTH-1:0]  occupancy
);

    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("pipe_elastic_reg: DEPTH must be in 1..4");
    end
    if ((1 << OCC_WIDTH) <= 2 * DEPTH) begin : g_bad_occ
        $error("pipe_elastic_reg: OCC_WIDTH too small for 2*DEPTH entries");
    end

    logic [DEPTH-1:0]      main_v_q, main_v_d;
    logic [DEPTH-1:0]      skid_v_q, skid_v_d;
    logic [CTRL_WIDTH-1:0] main_c_q [DEPTH];
    logic [CTRL_WIDTH-1:0] main_c_d [DEPTH];
    logic [CTRL_WIDTH-1:0] skid_c_q [DEPTH];
    logic [CTRL_WIDTH-1:0] skid_c_d [DEPTH];
    logic [DATA_WIDTH-1:0] main_d_q [DEPTH];
    logic [DATA_WIDTH-1:0] main_d_d [DEPTH];
    logic [DATA_WIDTH-1:0] skid_d_q [DEPTH];
    logic [DATA_WIDTH-1:0] skid_d_d [DEPTH];

    // link k is the input side of slice k; link DEPTH is the block output
    logic [DEPTH:0]        link_v;
    logic [DEPTH:0]        link_r;
    logic [CTRL_WIDTH-1:0] link_c [DEPTH+1];
    logic [DATA_WIDTH-1:0] link_d [DEPTH+1];

    always_comb begin
        link_v[0]     = in_valid;
        link_c[0]     = in_ctrl;
        link_d[0]     = in_data;
        link_r[DEPTH] = out_ready;
        for (int k = 0; k < DEPTH; k++) begin
            link_v[k+1] = main_v_q[k];
            link_c[k+1] = main_c_q[k];
            link_d[k+1] = main_d_q[k];
            link_r[k]   = !skid_v_q[k];
        end
    end

    assign in_ready  = link_r[0];
    assign out_valid = link_v[DEPTH];
    assign out_ctrl  = link_v[DEPTH] ? link_c[DEPTH] : '0;
    assign out_data  = link_d[DEPTH];

    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_c_d = main_c_q;
        skid_c_d = skid_c_q;
        main_d_d = main_d_q;
        skid_d_d = skid_d_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (!main_v_q[k]) begin
                if (link_v[k] && link_r[k]) begin
                    main_v_d[k] = 1'b1;
                    main_c_d[k] = link_c[k];
                    main_d_d[k] = link_d[k];
                end
            end else if (link_r[k+1]) begin
                if (skid_v_q[k]) begin
                    main_c_d[k] = skid_c_q[k];
                    main_d_d[k] = skid_d_q[k];
                    skid_v_d[k] = 1'b0;
                end else if (link_v[k]) begin
                    main_c_d[k] = link_c[k];
                    main_d_d[k] = link_d[k];
                end else begin
                    main_v_d[k] = 1'b0;
                end
            end else if (link_v[k] && link_r[k]) begin
                skid_v_d[k] = 1'b1;
                skid_c_d[k] = link_c[k];
                skid_d_d[k] = link_d[k];
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_WIDTH'(main_v_q[k]) + OCC_WIDTH'(skid_v_q[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_v_q <= '0;
            skid_v_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                main_c_q[k] <= '0;
                skid_c_q[k] <= '0;
                main_d_q[k] <= '0;
                skid_d_q[k] <= '0;
            end
        end else begin
            main_c_q <= main_c_d;
            skid_c_q <= skid_c_d;
            main_d_q <= main_d_d;
            skid_d_q <= skid_d_d;
            // flush only squashes valid bits; payload registers are don't-care when invalid
            if (flush) begin
                main_v_q <= '0;
                skid_v_q <= '0;
            end else begin
                main_v_q <= main_v_d;
                skid_v_q <= skid_v_d;
            end
        end
    end

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Bench for pipe_elastic_reg: three instances (DEPTH 1, 2, 4) checked against a FIFO-queue model.
module tb_pipe_elastic_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush     [3];
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [3:0]  in_ctrl   [3];
    logic [31:0] in_data   [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [3:0]  out_ctrl  [3];
    logic [31:0] out_data  [3];
    logic [3:0]  occupancy [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        pipe_elastic_reg #(.DATA_WIDTH(32), .CTRL_WIDTH(4), .DEPTH(D), .OCC_WIDTH(4)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_ctrl   (in_ctrl[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_ctrl  (out_ctrl[g]),
            .out_data  (out_data[g]),
            .occupancy (occupancy[g])
        );
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          sel      = 0;
    logic        last_acc;
    logic [35:0] model_q [$];

    function automatic int dep(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 4;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s (inst %0d): got 0x%0h expected 0x%0h at %0t", tag, sel, obs, exp, $time);
        end
    endtask

    // One clock cycle on the selected instance, entered and left at the falling edge.
    task automatic cyc(input logic v, input logic [3:0] c, input logic [31:0] d,
                       input logic ordy, input logic fl);
        logic        ix, ox;
        logic [35:0] e;
        in_valid[sel]  = v;
        in_ctrl[sel]   = c;
        in_data[sel]   = d;
        out_ready[sel] = ordy;
        flush[sel]     = fl;
        #1;
        ix = v && (in_ready[sel] === 1'b1);
        ox = ordy && (out_valid[sel] === 1'b1);
        last_acc = ix;
        if (ox && rst !== 1'b1) begin
            if (model_q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = model_q.pop_front();
                chk("out_beat", {out_ctrl[sel], out_data[sel]}, e);
            end
        end
        if (rst === 1'b1 || fl) model_q.delete();
        else if (ix) model_q.push_back({c, d});
        @(posedge clk);
        @(negedge clk);
        chk("occupancy", occupancy[sel], model_q.size());
        if (out_valid[sel] !== 1'b1) chk("bubble_ctrl", out_ctrl[sel], 0);
        if (model_q.size() == 0) chk("empty_valid", out_valid[sel], 0);
        if (model_q.size() == 2 * dep(sel)) chk("full_ready", in_ready[sel], 0);
        if (dep(sel) == 1) begin
            chk("d1_valid", out_valid[sel], model_q.size() > 0);
            chk("d1_ready", in_ready[sel], model_q.size() < 2);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (model_q.size() != 0 && n < 40) begin
            cyc(0, 0, 0, 1, 0);
            n++;
        end
        chk("drain_done", model_q.size(), 0);
    endtask

    task automatic offer_until(input logic [3:0] c, input logic [31:0] d, input logic ordy);
        int n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 20) begin
            cyc(1, c, d, ordy, 0);
            n++;
        end
        chk("offer_accepted", last_acc, 1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            flush[i] = 0; in_valid[i] = 0; in_ctrl[i] = 0;
            in_data[i] = 0; out_ready[i] = 0;
        end
        @(negedge clk);

        // reset held two cycles with a beat offered, DEPTH=1
        sel = 0;
        rst = 1'b1;
        cyc(1, 4'h5, 32'hDEAD, 1, 0);
        cyc(1, 4'h5, 32'hDEAD, 1, 0);
        rst = 1'b0;
        chk("rst_out_valid", out_valid[0], 0);
        chk("rst_occ", occupancy[0], 0);
        chk("rst_out_ctrl", out_ctrl[0], 0);
        chk("rst_out_data", out_data[0], 0);
        chk("rst_in_ready", in_ready[0], 1);
        model_q.delete();

        // streaming, DEPTH=2: each beat appears two cycles after it is driven
        sel = 1;
        do_reset();
        for (int t = 0; t < 12; t++) begin
            if (t >= 2 && t < 10) begin
                chk("stream_valid", out_valid[1], 1);
                chk("stream_data", out_data[1], 32'h10 + t - 2);
            end
            if (t >= 2 && t < 8) chk("stream_occ", occupancy[1], 2);
            if (t < 8) cyc(1, 4'h1, 32'h10 + t, 1, 0);
            else cyc(0, 0, 0, 1, 0);
        end
        chk("stream_empty", model_q.size(), 0);

        // back-pressure, DEPTH=1
        sel = 0;
        do_reset();
        cyc(1, 4'h2, 32'hA, 0, 0);
        cyc(1, 4'h2, 32'hB, 0, 0);
        chk("bp_in_ready", in_ready[0], 0);
        chk("bp_occ", occupancy[0], 2);
        cyc(1, 4'h2, 32'hC, 0, 0);
        chk("bp_c_held", last_acc, 0);
        cyc(1, 4'h2, 32'hC, 0, 0);
        offer_until(4'h2, 32'hC, 1);
        drain();

        // head leaves and a beat enters in the same cycle; occupancy holds
        cyc(1, 4'h3, 32'h1, 0, 0);
        chk("sim_occ_before", occupancy[0], 1);
        cyc(1, 4'h3, 32'h2, 1, 0);
        chk("sim_both_acc", last_acc, 1);
        chk("sim_occ_after", occupancy[0], 1);
        cyc(1, 4'h3, 32'h3, 1, 0);
        chk("sim_occ_after2", occupancy[0], 1);
        drain();

        // flush a full DEPTH=2 instance while a beat is offered
        sel = 1;
        do_reset();
        for (int i = 0; i < 4; i++) offer_until(4'hF, 32'h20 + i, 0);
        chk("fl_full_occ", occupancy[1], 4);
        chk("fl_full_ready", in_ready[1], 0);
        cyc(1, 4'h7, 32'h55, 0, 1);
        chk("fl_occ", occupancy[1], 0);
        chk("fl_valid", out_valid[1], 0);
        chk("fl_ctrl", out_ctrl[1], 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);

        // mid-stream reset, DEPTH=4
        sel = 2;
        do_reset();
        for (int i = 0; i < 5; i++) offer_until(4'h9, 32'h40 + i, 0);
        chk("mr_occ", occupancy[2], 5);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        rst = 1'b0;
        chk("mr_occ_after", occupancy[2], 0);
        chk("mr_valid_after", out_valid[2], 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0);

        // randomized traffic on each instance
        for (int s = 0; s < 3; s++) begin
            sel = s;
            do_reset();
            for (int t = 0; t < 400; t++) begin
                cyc(($urandom % 4) != 0, 4'($urandom), $urandom,
                    ($urandom % 3) != 0, ($urandom % 50) == 0);
            end
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
